// File: rtl/time_pkg.sv
// Shared BCD types, constants and helpers for the time-of-day counter.
package time_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned BCD_PAIR_W  = 2 * BCD_DIGIT_W;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd2_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } ld_state_t;

    localparam bcd2_t      BCD_59        = 8'h59;
    localparam bcd_digit_t SEC_DIGIT_MAX = 4'd9;

    // True when both digits are decimal and the pair does not exceed max.
    function automatic logic bcd_valid(input bcd2_t value, input bcd2_t max);
        return (value.tens <= SEC_DIGIT_MAX) && (value.units <= SEC_DIGIT_MAX) &&
               ({value.tens, value.units} <= {max.tens, max.units});
    endfunction

    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        if (v.units == SEC_DIGIT_MAX) begin
            r.tens  = v.tens + 4'd1;
            r.units = 4'd0;
        end else begin
            r.tens  = v.tens;
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd2_t to_bcd(input int unsigned v);
        bcd2_t r;
        r.tens  = BCD_DIGIT_W'(v / 10);
        r.units = BCD_DIGIT_W'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter; wraps to 00 after {TENS_MAX, UNITS_MAX_AT_TOP}.
module bcd_mod_cnt #(
    parameter int unsigned TENS_MAX         = 5,
    parameter int unsigned UNITS_MAX_AT_TOP = 9
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       wrap_c
);
    import time_pkg::*;

    localparam bcd2_t TOP = {BCD_DIGIT_W'(TENS_MAX), BCD_DIGIT_W'(UNITS_MAX_AT_TOP)};

    bcd2_t value_q;
    logic  at_top_c;

    assign at_top_c = (value_q == TOP);
    assign wrap_c   = inc && at_top_c;
    assign value    = value_q;

    // Load has priority over increment.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (inc) begin
            value_q <= at_top_c ? bcd2_t'('0) : bcd_inc(value_q);
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with req/ack time load and run/pause.
// Optional alarm (ports alarm_set/alarm_hh/alarm_mm/alarm_out) built when TIME_ALARM_EN is defined.
module bcd_time_counter #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load_req,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic       load_ack,
    output logic       load_err,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       min_pulse,
    output logic       day_pulse
`ifdef TIME_ALARM_EN
    ,
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic       alarm_out
`endif
);
    import time_pkg::*;

    localparam int unsigned           PRESC_W    = 8;
    localparam logic [PRESC_W-1:0]    PRESC_TOP  = PRESC_W'(TICK_DIV - 1);
    localparam bcd2_t                 HH_MAX_BCD = to_bcd(HOUR_MAX);

    ld_state_t          state_q, state_d;
    logic               ack_d;
    logic               capture_c;
    logic               load_ok_c;
    logic               do_load_c;
    logic [PRESC_W-1:0] presc_q;
    logic               tick_cnt_c;
    logic               step_c;
    logic               step_en_c;
    logic               ss_wrap_c, mm_wrap_c, hh_wrap_c;

    // Load handshake: one capture per request, ack held until req drops.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d   = S_ACK;
                    ack_d     = 1'b1;
                    capture_c = 1'b1;
                end
            end
            S_ACK: begin
                if (load_req) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            load_ack <= 1'b0;
        end else begin
            state_q  <= state_d;
            load_ack <= ack_d;
        end
    end

    assign load_ok_c = bcd_valid(load_hh, HH_MAX_BCD) &&
                       bcd_valid(load_mm, BCD_59) &&
                       bcd_valid(load_ss, BCD_59);
    assign do_load_c = capture_c && load_ok_c;

    // Prescaler; any capture discards a coincident second step.
    assign tick_cnt_c = run && tick_in;
    assign step_c     = tick_cnt_c && (presc_q == PRESC_TOP);
    assign step_en_c  = step_c && !capture_c;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (do_load_c) begin
            presc_q <= '0;
        end else if (tick_cnt_c) begin
            presc_q <= step_c ? '0 : presc_q + PRESC_W'(1);
        end
    end

    bcd_mod_cnt #(.TENS_MAX(5), .UNITS_MAX_AT_TOP(9)) u_ss (
        .clk_in   (clk_in),
        .rst      (rst),
        .inc      (step_en_c),
        .load     (do_load_c),
        .load_val (load_ss),
        .value    (ss_bcd),
        .wrap_c   (ss_wrap_c)
    );

    bcd_mod_cnt #(.TENS_MAX(5), .UNITS_MAX_AT_TOP(9)) u_mm (
        .clk_in   (clk_in),
        .rst      (rst),
        .inc      (ss_wrap_c),
        .load     (do_load_c),
        .load_val (load_mm),
        .value    (mm_bcd),
        .wrap_c   (mm_wrap_c)
    );

    bcd_mod_cnt #(.TENS_MAX(HOUR_MAX / 10), .UNITS_MAX_AT_TOP(HOUR_MAX % 10)) u_hh (
        .clk_in   (clk_in),
        .rst      (rst),
        .inc      (mm_wrap_c),
        .load     (do_load_c),
        .load_val (load_hh),
        .value    (hh_bcd),
        .wrap_c   (hh_wrap_c)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            load_err  <= 1'b0;
            min_pulse <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            load_err  <= capture_c && !load_ok_c;
            min_pulse <= ss_wrap_c;
            day_pulse <= hh_wrap_c;
        end
    end

`ifdef TIME_ALARM_EN
    bcd2_t alarm_hh_q, alarm_mm_q;
    bcd2_t mm_next_c, hh_next_c;
    logic  alarm_hit_c;

    // Predict the post-step time so the pulse lines up with the step edge.
    always_comb begin
        mm_next_c   = mm_wrap_c ? bcd2_t'('0) : bcd_inc(mm_bcd);
        hh_next_c   = hh_wrap_c ? bcd2_t'('0) : (mm_wrap_c ? bcd_inc(hh_bcd) : bcd2_t'(hh_bcd));
        alarm_hit_c = ss_wrap_c && (mm_next_c == alarm_mm_q) && (hh_next_c == alarm_hh_q);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            alarm_hh_q <= '0;
            alarm_mm_q <= '0;
            alarm_out  <= 1'b0;
        end else begin
            if (alarm_set && bcd_valid(alarm_hh, HH_MAX_BCD) && bcd_valid(alarm_mm, BCD_59)) begin
                alarm_hh_q <= alarm_hh;
                alarm_mm_q <= alarm_mm;
            end
            alarm_out <= alarm_hit_c;
        end
    end
`endif

endmodule
